// File: rtl/mov_avg_pkg.sv
// Shared state encoding, default widths and counter sizing for the
// moving-average controller slice.
package mov_avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FILL  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam int DEF_WINDOW_LEN   = 128;
  localparam int DEF_DIN_WIDTH    = 25;
  localparam int DEF_FLUSH_CYCLES = 8;
  localparam int DEF_TS_WIDTH     = 48;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mov_avg_ctrl_cnt.sv
// Loadable up/down counter with a terminal flag that compares the current
// count against a caller-supplied terminal value.
module mov_avg_ctrl_cnt #(
  parameter int WIDTH = 8,
  parameter bit UP    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic [WIDTH-1:0] term_val,
  output logic             term
);

  logic [WIDTH-1:0] count_reg;

  // Load wins over step so a reload on the same edge always restarts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (ce) begin
      if (load) begin
        count_reg <= load_val;
      end else if (step) begin
        count_reg <= UP ? count_reg + 1'b1 : count_reg - 1'b1;
      end
    end
  end

  assign term = (count_reg == term_val);

endmodule

// File: rtl/mov_avg_ctrl.sv
// Sequences an external moving-average block: flush it, wait for a full
// window of results, then forward timestamped averages.
module mov_avg_ctrl
  import mov_avg_pkg::*;
#(
  parameter int WINDOW_LEN   = DEF_WINDOW_LEN,
  parameter int DIN_WIDTH    = DEF_DIN_WIDTH,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int TS_WIDTH     = DEF_TS_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        enable,
  input  logic                        restart,
  input  logic signed [DIN_WIDTH-1:0] din,
  input  logic                        din_valid,
  output logic                        avg_rst,
  output logic signed [DIN_WIDTH-1:0] avg_din,
  output logic                        avg_din_valid,
  input  logic signed [DIN_WIDTH-1:0] avg_dout,
  input  logic                        avg_dout_valid,
  output logic signed [DIN_WIDTH-1:0] dout,
  output logic                        dout_valid,
  output logic [TS_WIDTH-1:0]         dout_ts,
  output logic [1:0]                  state,
  output logic                        dropped
);

  localparam int FLUSH_W = cnt_width(FLUSH_CYCLES);
  localparam int FILL_W  = cnt_width(WINDOW_LEN);

  state_t                      state_reg;
  logic                        avg_rst_reg;
  logic signed [DIN_WIDTH-1:0] avg_din_reg;
  logic                        avg_din_valid_reg;
  logic signed [DIN_WIDTH-1:0] dout_reg;
  logic                        dout_valid_reg;
  logic [TS_WIDTH-1:0]         dout_ts_reg;
  logic [TS_WIDTH-1:0]         ts_reg;
  logic                        dropped_reg;

  logic flush_load, flush_step, flush_term;
  logic fill_load, fill_step, fill_term;
  logic normal_next;

  // Counters follow the same priority as the FSM: enable low or restart
  // override the per-state stepping.
  assign normal_next = enable && !restart;
  assign flush_load  = enable && (restart || state_reg == ST_IDLE);
  assign flush_step  = normal_next && state_reg == ST_FLUSH;
  assign fill_load   = !normal_next || state_reg != ST_FILL;
  assign fill_step   = normal_next && state_reg == ST_FILL && avg_dout_valid;

  mov_avg_ctrl_cnt #(
    .WIDTH (FLUSH_W),
    .UP    (1'b0)
  ) u_flush_cnt (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .load     (flush_load),
    .load_val (FLUSH_W'(FLUSH_CYCLES)),
    .step     (flush_step),
    .term_val (FLUSH_W'(1)),
    .term     (flush_term)
  );

  mov_avg_ctrl_cnt #(
    .WIDTH (FILL_W),
    .UP    (1'b1)
  ) u_fill_cnt (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .load     (fill_load),
    .load_val ('0),
    .step     (fill_step),
    .term_val (FILL_W'(WINDOW_LEN - 1)),
    .term     (fill_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      avg_rst_reg       <= 1'b1;
      avg_din_reg       <= '0;
      avg_din_valid_reg <= 1'b0;
      dout_reg          <= '0;
      dout_valid_reg    <= 1'b0;
      dout_ts_reg       <= '0;
      ts_reg            <= '0;
      dropped_reg       <= 1'b0;
    end else begin
      // Qualifiers are single-cycle; anything not re-asserted below drops.
      avg_din_valid_reg <= 1'b0;
      dout_valid_reg    <= 1'b0;
      if (ce) begin
        if (!enable) begin
          state_reg   <= ST_IDLE;
          avg_rst_reg <= 1'b1;
          dropped_reg <= 1'b0;
          ts_reg      <= '0;
        end else if (restart) begin
          state_reg   <= ST_FLUSH;
          avg_rst_reg <= 1'b1;
          dropped_reg <= 1'b0;
          ts_reg      <= '0;
        end else begin
          if (din_valid && (state_reg == ST_IDLE || state_reg == ST_FLUSH)) begin
            dropped_reg <= 1'b1;
          end
          case (state_reg)
            ST_IDLE: begin
              state_reg   <= ST_FLUSH;
              avg_rst_reg <= 1'b1;
              ts_reg      <= '0;
            end
            ST_FLUSH: begin
              ts_reg <= '0;
              if (flush_term) begin
                state_reg   <= ST_FILL;
                avg_rst_reg <= 1'b0;
              end
            end
            ST_FILL, ST_RUN: begin
              avg_rst_reg       <= 1'b0;
              avg_din_reg       <= din;
              avg_din_valid_reg <= din_valid;
              if (avg_dout_valid) begin
                ts_reg <= ts_reg + 1'b1;
                if (state_reg == ST_RUN) begin
                  dout_reg       <= avg_dout;
                  dout_valid_reg <= 1'b1;
                  dout_ts_reg    <= ts_reg;
                end else if (fill_term) begin
                  // The window-completing result is swallowed, not forwarded.
                  state_reg <= ST_RUN;
                end
              end
            end
            default: state_reg <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign avg_rst       = avg_rst_reg;
  assign avg_din       = avg_din_reg;
  assign avg_din_valid = avg_din_valid_reg;
  assign dout          = dout_reg;
  assign dout_valid    = dout_valid_reg;
  assign dout_ts       = dout_ts_reg;
  assign state         = state_reg;
  assign dropped       = dropped_reg;

endmodule

// File: doc/mov_avg_ctrl.md
MOV_AVG_CTRL -- requirements
Module: mov_avg_ctrl

Interface
REQ-001 SHALL have parameter WINDOW_LEN, default 128: moving-average window; outputs needed before the block enters RUN.
REQ-002 SHALL have parameter DIN_WIDTH, default 25: sample width, signed.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 8: cycles avg_rst is held after leaving IDLE.
REQ-004 SHALL have parameter TS_WIDTH, default 48: timestamp width.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-007 SHALL have port ce, input, 1: clock enable.
REQ-008 SHALL have port enable, input, 1: level; 1 = run the averager.
REQ-009 SHALL have port restart, input, 1: single-cycle pulse; re-flush and refill.
REQ-010 SHALL have port din, input, DIN_WIDTH signed: upstream sample.
REQ-011 SHALL have port din_valid, input, 1: din qualifier.
REQ-012 SHALL have port avg_rst, output, 1: reset to the averager.
REQ-013 SHALL have port avg_din, output, DIN_WIDTH signed: sample to the averager.
REQ-014 SHALL have port avg_din_valid, output, 1: avg_din qualifier.
REQ-015 SHALL have port avg_dout, input, DIN_WIDTH signed: averager result.
REQ-016 SHALL have port avg_dout_valid, input, 1: avg_dout qualifier.
REQ-017 SHALL have port dout, output, DIN_WIDTH signed: gated average.
REQ-018 SHALL have port dout_valid, output, 1: dout qualifier.
REQ-019 SHALL have port dout_ts, output, TS_WIDTH: timestamp of dout.
REQ-020 SHALL have port state, output, 2: current FSM state code.
REQ-021 SHALL have port dropped, output, 1: sticky flag; a sample was discarded.

Function
REQ-022 SHALL implement the FSM states IDLE=0, FLUSH=1, FILL=2 and RUN=3.
REQ-023 SHALL hold all registers when ce=0, except dout_valid and avg_din_valid, which clear at the next edge.
REQ-024 SHALL use the transition priority rst > enable=0 (go to IDLE) > restart (go to FLUSH) > the normal transitions.
REQ-025 SHALL, in IDLE, hold avg_rst=1 and go to FLUSH on the first edge where enable=1.
REQ-026 SHALL, in FLUSH, hold avg_rst=1 for exactly FLUSH_CYCLES edges, then go to FILL.
REQ-027 SHALL, in FILL or RUN, hold avg_rst=0 and register avg_din<=din and avg_din_valid<=din_valid, giving 1-cycle latency.
REQ-028 SHALL force avg_din_valid=0 outside FILL and RUN.
REQ-029 SHALL set dropped on any din_valid=1 seen in FLUSH, or in IDLE while enable=1.
REQ-030 SHALL clear dropped on restart or on entering IDLE.
REQ-031 SHALL keep a fill counter that counts avg_dout_valid pulses in FILL and suppresses dout_valid there.
REQ-032 SHALL go to RUN on the edge of the WINDOW_LEN-th pulse; that pulse itself SHALL NOT be forwarded.
REQ-033 SHALL, in RUN, register dout<=avg_dout and dout_valid<=avg_dout_valid, giving 1-cycle latency.
REQ-034 SHALL hold dout at its last value when dout_valid=0.
REQ-035 SHALL keep a timestamp counter ts_cnt (TS_WIDTH) that increments on each avg_dout_valid pulse in FILL or RUN.
REQ-036 SHALL clear ts_cnt in IDLE and FLUSH, and SHALL let it wrap modulo 2^TS_WIDTH with no flag.
REQ-037 SHALL register dout_ts with the ts_cnt value before increment alongside dout, so the first RUN output carries ts = WINDOW_LEN.
REQ-038 SHALL clear dout_valid on the edge that leaves RUN for any reason; pipeline samples in flight are discarded.
REQ-039 SHALL let a restart during FLUSH reload the flush counter to FLUSH_CYCLES.
REQ-040 SHALL ignore avg_dout_valid in IDLE and FLUSH.
REQ-041 SHALL set state equal to the registered FSM state code.

Reset
REQ-042 SHALL, on rst=1 at a clk edge (regardless of ce), enter IDLE.
REQ-043 SHALL, on that reset, set avg_rst=1.
REQ-044 SHALL, on that reset, set avg_din_valid=0, dout_valid=0 and dropped=0.
REQ-045 SHALL, on that reset, set avg_din=0, dout=0, dout_ts=0 and state=0.
REQ-046 SHALL, on that reset, clear the flush, fill and ts counters.
REQ-047 SHALL make reset in mid-operation take effect on the same edge, with no output pulse after it.

Structure
REQ-048 SHALL take the state encoding, the default widths and the FLUSH_CYCLES default from a shared package, mov_avg_pkg.
REQ-049 SHALL instantiate one sub-module, mov_avg_ctrl_cnt: a loadable down/up counter with terminal flag, used for the flush and fill counts.
REQ-050 SHALL NOT instantiate the averager; the parent wires it through the avg_* ports.

Verification
REQ-051 SHALL cover this case: rst high 3 cycles, then enable=1 -> avg_rst high through IDLE plus exactly 8 FLUSH cycles, then state=2.
REQ-052 SHALL cover this case: a model averager (latency 2) fed continuous din=0x100000 -> no dout_valid for the first 128 outputs; the first dout_valid has dout_ts=128 and the next has 129.
REQ-053 SHALL cover this case: din_valid=1 during FLUSH -> dropped=1; a restart pulse clears dropped and re-runs 8 flush cycles.
REQ-054 SHALL cover this case: enable dropped mid-RUN -> dout_valid=0 on the next edge, state=0, avg_rst=1.
REQ-055 SHALL cover this case: ce toggled 1/0 in RUN -> dout_valid only on ce=1 edges, and ts_cnt unchanged across ce=0.
REQ-056 SHALL cover this case: TS_WIDTH=4 with ts preloaded near the top -> dout_ts wraps 15 -> 0 with no other effect.
